// File: rtl/ahb_lite_master.sv
// Single-outstanding-per-slot AHB-Lite initiator: turns a valid/ready request port into
// pipelined address/data phases and returns one in-order response per accepted request.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_ADDR,
    input  logic        REQ_WRITE,
    input  logic [1:0]  REQ_SIZE,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [1:0]  M_HTRANS,
    output logic [31:0] M_HADDR,
    output logic        M_HWRITE,
    output logic [2:0]  M_HSIZE,
    output logic [2:0]  M_HBURST,
    output logic        M_HMASTLOCK,
    output logic [3:0]  M_HPROT,
    output logic [31:0] M_HWDATA,
    input  logic        M_HREADY,
    input  logic [31:0] M_HRDATA,
    input  logic        M_HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Misaligned halfword/word or the reserved size code never reaches the bus.
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] read_extract(input logic [1:0] size, input logic [1:0] addr_lo,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = rdata >> {addr_lo, 3'b000};
        case (size)
            2'b00:   result = {24'd0, shifted[7:0]};
            2'b01:   result = addr_lo[1] ? {16'd0, rdata[31:16]} : {16'd0, rdata[15:0]};
            default: result = rdata;
        endcase
        return result;
    endfunction

    logic        a_valid_r;
    logic [31:0] a_addr_r;
    logic        a_write_r;
    logic [1:0]  a_size_r;
    logic [31:0] a_wdata_r;
    logic        a_bad_r;
    logic [1:0]  htrans_r;

    logic        d_valid_r;
    logic [1:0]  d_addr_lo_r;
    logic        d_write_r;
    logic [1:0]  d_size_r;
    logic        d_bad_r;
    logic [31:0] hwdata_r;

    logic        cancel_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;

    logic        err1_s;
    logic        ready_s;
    logic        accept_s;
    logic        d_done_s;
    logic        a_valid_nxt_s;
    logic        a_bad_nxt_s;
    logic        rsp_err_s;

    // Handshake and next-state of the address slot.
    always_comb begin
        err1_s        = d_valid_r & M_HRESP & ~M_HREADY;
        ready_s       = ~err1_s & (~a_valid_r | M_HREADY);
        accept_s      = REQ_VALID & ready_s;
        d_done_s      = d_valid_r & M_HREADY;
        rsp_err_s     = M_HRESP | d_bad_r;
        a_valid_nxt_s = a_valid_r;
        a_bad_nxt_s   = a_bad_r;
        if (err1_s) begin
            a_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            a_valid_nxt_s = 1'b1;
            a_bad_nxt_s   = is_bad(REQ_SIZE, REQ_ADDR[1:0]);
        end else if (M_HREADY) begin
            a_valid_nxt_s = 1'b0;
        end else begin
            a_valid_nxt_s = a_valid_r;
        end
    end

    // Address slot; its fields drive the bus address/control directly.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            a_valid_r <= 1'b0;
            a_addr_r  <= 32'd0;
            a_write_r <= 1'b0;
            a_size_r  <= 2'b00;
            a_wdata_r <= 32'd0;
            a_bad_r   <= 1'b0;
            htrans_r  <= HTRANS_IDLE;
        end else begin
            a_valid_r <= a_valid_nxt_s;
            a_bad_r   <= a_bad_nxt_s;
            htrans_r  <= (a_valid_nxt_s & ~a_bad_nxt_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (accept_s) begin
                a_addr_r  <= REQ_ADDR;
                a_write_r <= REQ_WRITE;
                a_size_r  <= REQ_SIZE;
                a_wdata_r <= REQ_WDATA;
            end
        end
    end

    // Data slot follows the address slot whenever the bus is ready.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            d_valid_r   <= 1'b0;
            d_addr_lo_r <= 2'b00;
            d_write_r   <= 1'b0;
            d_size_r    <= 2'b00;
            d_bad_r     <= 1'b0;
            hwdata_r    <= 32'd0;
        end else if (M_HREADY) begin
            d_valid_r   <= a_valid_r;
            d_addr_lo_r <= a_addr_r[1:0];
            d_write_r   <= a_write_r;
            d_size_r    <= a_size_r;
            d_bad_r     <= a_bad_r;
            hwdata_r    <= (a_valid_r & a_write_r) ? lane_wdata(a_size_r, a_wdata_r) : 32'd0;
        end
    end

    // Response register; a cancelled request answers once the failing transfer has.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            cancel_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
        end else begin
            if (err1_s & a_valid_r) begin
                cancel_r <= 1'b1;
            end else if (cancel_r & ~d_valid_r) begin
                cancel_r <= 1'b0;
            end
            if (d_done_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= rsp_err_s;
                rsp_rdata_r <= (rsp_err_s | d_write_r) ? 32'd0
                             : read_extract(d_size_r, d_addr_lo_r, M_HRDATA);
            end else if (cancel_r & ~d_valid_r) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= 1'b1;
                rsp_rdata_r <= 32'd0;
            end else begin
                rsp_valid_r <= 1'b0;
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= 32'd0;
            end
        end
    end

    assign REQ_READY   = ready_s;
    assign RSP_VALID   = rsp_valid_r;
    assign RSP_ERR     = rsp_err_r;
    assign RSP_RDATA   = rsp_rdata_r;
    assign M_HTRANS    = htrans_r;
    assign M_HADDR     = a_addr_r;
    assign M_HWRITE    = a_write_r;
    assign M_HSIZE     = {1'b0, a_size_r};
    assign M_HBURST    = 3'b000;
    assign M_HMASTLOCK = 1'b0;
    assign M_HPROT     = HPROT_VALUE;
    assign M_HWDATA    = hwdata_r;

endmodule
